// File: rtl/mem_arb_pkg.sv
// Shared types, limits and the arbitration helper for mem_req_arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_MAX_PORTS = 8;

    typedef logic [2:0] mem_arb_id_t;

    // First set bit of req at or after ptr, wrapping modulo 8. Bits at or
    // above the real port count are always zero, so this equals a search
    // modulo N_PORTS. Returns 0 when req is empty.
    function automatic mem_arb_id_t rr_pick(input logic [MEM_ARB_MAX_PORTS-1:0] req,
                                            input mem_arb_id_t                  ptr);
        mem_arb_id_t pick;
        mem_arb_id_t idx;
        pick = '0;
        for (int k = MEM_ARB_MAX_PORTS - 1; k >= 0; k--) begin
            idx = ptr + mem_arb_id_t'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO holding the port ID of every accepted request until its
// response comes back. Pointers wrap modulo DEPTH, so any DEPTH >= 1 works.
module mem_arb_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one req/gnt/r_valid memory port between N_PORTS requesters and
// routes responses back in order. Define MEM_ARB_RR_EN for round-robin;
// otherwise fixed priority with the lowest index winning.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             s_req_i,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]  s_add_i,
    input  logic [N_PORTS-1:0]             s_wen_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]  s_wdata_i,
    input  logic [N_PORTS*BE_WIDTH-1:0]    s_be_i,
    output logic [N_PORTS-1:0]             s_gnt_o,
    output logic [N_PORTS-1:0]             s_r_valid_o,
    output logic [DATA_WIDTH-1:0]          s_r_rdata_o,
    output logic                           m_req_o,
    output logic [ADDR_WIDTH-1:0]          m_add_o,
    output logic                           m_wen_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [BE_WIDTH-1:0]            m_be_o,
    input  logic                           m_gnt_i,
    input  logic                           m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          m_r_rdata_i,
    output logic                           err_o
);

    localparam int ID_W = $clog2(N_PORTS);

    logic [MEM_ARB_MAX_PORTS-1:0] elig;
    mem_arb_id_t                  ptr, sel;
    logic                         any_elig, handshake, pop;
    logic                         fifo_full, fifo_empty;
    logic [ID_W-1:0]              head;
    logic                         err_q, err_d;

    // Eligibility looks only at the registered FIFO state; a pop this cycle
    // does not free a slot until the next one.
    always_comb begin
        elig              = '0;
        elig[N_PORTS-1:0] = s_req_i & {N_PORTS{~fifo_full}};
    end

    assign sel       = rr_pick(elig, ptr);
    assign any_elig  = |elig;
    assign handshake = any_elig & m_gnt_i;
    assign pop       = m_r_valid_i & ~fifo_empty;

    always_comb begin
        m_req_o   = any_elig;
        m_add_o   = '0;
        m_wen_o   = 1'b0;
        m_wdata_o = '0;
        m_be_o    = '0;
        if (any_elig) begin
            m_add_o   = s_add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            m_wen_o   = s_wen_i[int'(sel)];
            m_wdata_o = s_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            m_be_o    = s_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
        end
    end

    always_comb begin
        s_gnt_o     = '0;
        s_r_valid_o = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            s_gnt_o[i]     = handshake & (sel == mem_arb_id_t'(i));
            s_r_valid_o[i] = pop & (head == ID_W'(i));
        end
    end

    assign s_r_rdata_o = m_r_rdata_i;

    mem_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (handshake),
        .pop   (pop),
        .din   (sel[ID_W-1:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MEM_ARB_RR_EN
    // ptr_q holds the port where the next search starts.
    mem_arb_id_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (sel == mem_arb_id_t'(N_PORTS - 1)) ? '0 : sel + mem_arb_id_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign err_d = err_q | (m_r_valid_i & fifo_empty);
    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter with a behavioural memory, a
// reference arbitration model and an in-order response scoreboard.
module tb_mem_req_arbiter;

    localparam int N    = 2;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int EW   = 8 + DW;
    localparam int FW   = AW + 1 + DW + BW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    s_req_i;
    logic [N*AW-1:0] s_add_i;
    logic [N-1:0]    s_wen_i;
    logic [N*DW-1:0] s_wdata_i;
    logic [N*BW-1:0] s_be_i;
    logic [N-1:0]    s_gnt_o;
    logic [N-1:0]    s_r_valid_o;
    logic [DW-1:0]   s_r_rdata_o;
    logic            m_req_o;
    logic [AW-1:0]   m_add_o;
    logic            m_wen_o;
    logic [DW-1:0]   m_wdata_o;
    logic [BW-1:0]   m_be_o;
    logic            m_gnt_i = 1'b0;
    logic            m_r_valid_i;
    logic [DW-1:0]   m_r_rdata_i;
    logic            err_o;

    mem_req_arbiter #(
        .N_PORTS         (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BE_WIDTH        (BW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_req_i     (s_req_i),
        .s_add_i     (s_add_i),
        .s_wen_i     (s_wen_i),
        .s_wdata_i   (s_wdata_i),
        .s_be_i      (s_be_i),
        .s_gnt_o     (s_gnt_o),
        .s_r_valid_o (s_r_valid_o),
        .s_r_rdata_o (s_r_rdata_o),
        .m_req_o     (m_req_o),
        .m_add_o     (m_add_o),
        .m_wen_o     (m_wen_o),
        .m_wdata_o   (m_wdata_o),
        .m_be_o      (m_be_o),
        .m_gnt_i     (m_gnt_i),
        .m_r_valid_i (m_r_valid_i),
        .m_r_rdata_i (m_r_rdata_i),
        .err_o       (err_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- requester state ----------------
    logic          r_req   [N];
    logic          r_wen   [N];
    logic [AW-1:0] r_add   [N];
    logic [DW-1:0] r_wdata [N];
    logic [BW-1:0] r_be    [N];

    int req_pct   = 0;
    int gnt_pct   = 100;
    int lat       = 1;
    int load_only = 0;
    int stray_cnt = 0;
    int rst_kind  = 0;

    always_comb begin
        s_req_i   = '0;
        s_add_i   = '0;
        s_wen_i   = '0;
        s_wdata_i = '0;
        s_be_i    = '0;
        for (int p = 0; p < N; p++) begin
            s_req_i[p]             = r_req[p];
            s_wen_i[p]             = r_wen[p];
            s_add_i[p*AW +: AW]    = r_add[p];
            s_wdata_i[p*DW +: DW]  = r_wdata[p];
            s_be_i[p*BW +: BW]     = r_be[p];
        end
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] bmem    [0:(1<<AW)-1];
    logic [DW-1:0] last_rdata [N];
    int            cnt     = 0;
    int            last    = N - 1;
    logic          exp_err = 1'b0;
    int            n_vec   = 0;
    int            n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: round-robin from the port after the last
    // winner, or plain lowest index. Returns -1 when nobody is eligible.
    function automatic int pick(input logic [N-1:0] e);
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (e[(last + 1 + k) % N]) return (last + 1 + k) % N;
        end
`else
        for (int p = 0; p < N; p++) begin
            if (e[p]) return p;
        end
`endif
        return -1;
    endfunction

    // ---------------- behavioural memory ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    resp_t pipe[$];

    initial begin
        int            cyc;
        int            stray_done;
        logic          in_rst;
        logic [DW-1:0] d;
        cyc         = 0;
        stray_done  = 0;
        m_r_valid_i = 1'b0;
        m_r_rdata_i = '0;
        forever begin
            @(posedge clk);
            in_rst = rst;
            if (in_rst) begin
                pipe.delete();
            end else if (m_req_o && m_gnt_i) begin
                d = '0;
                if (m_wen_o) begin
                    d = bmem[m_add_o];
                end else begin
                    for (int b = 0; b < BW; b++)
                        if (m_be_o[b]) bmem[m_add_o][b*8 +: 8] = m_wdata_o[b*8 +: 8];
                end
                pipe.push_back('{cyc + lat, d});
            end
            cyc++;
            #1;
            m_r_valid_i = 1'b0;
            m_r_rdata_i = '0;
            if (!in_rst && pipe.size() > 0 && pipe[0].due == cyc) begin
                m_r_valid_i = 1'b1;
                m_r_rdata_i = pipe[0].data;
                void'(pipe.pop_front());
            end else if (!in_rst && stray_done != stray_cnt) begin
                m_r_valid_i = 1'b1;
                m_r_rdata_i = $urandom;
                stray_done++;
            end
        end
    end

    // ---------------- reference checker (pushes expectations) ----------------
    initial begin
        logic [N-1:0]  elig;
        logic [N-1:0]  exp_gnt;
        logic [FW-1:0] exp_f;
        logic [DW-1:0] d;
        logic          post_rst;
        int            s;
        post_rst = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                cnt      = 0;
                last     = N - 1;
                exp_err  = 1'b0;
                post_rst = 1'b1;
                exp_q.delete();
            end else begin
                if (post_rst && rst_kind == 1) begin
                    check("rst_err_clear", err_o, 0);
                    check("rst_port0_prio", s_gnt_o, 1);
                end
                post_rst = 1'b0;
                elig = '0;
                for (int p = 0; p < N; p++) elig[p] = r_req[p] && (cnt < MAXO);
                s = pick(elig);
                check("m_req", m_req_o, s >= 0);
                exp_f = '0;
                if (s >= 0) exp_f = {r_add[s], r_wen[s], r_wdata[s], r_be[s]};
                check("m_fields", {m_add_o, m_wen_o, m_wdata_o, m_be_o}, exp_f);
                exp_gnt = '0;
                if (s >= 0 && m_gnt_i) exp_gnt[s] = 1'b1;
                check("s_gnt", s_gnt_o, exp_gnt);
                check("rvalid_any", |s_r_valid_o, m_r_valid_i && cnt > 0);
                check("rdata_pass", s_r_rdata_o, m_r_rdata_i);
                check("err", err_o, exp_err);
                if (m_r_valid_i) begin
                    if (cnt > 0) cnt--;
                    else         exp_err = 1'b1;
                end
                if (s >= 0 && m_gnt_i) begin
                    d = '0;
                    if (r_wen[s]) begin
                        d = ref_mem[r_add[s]];
                    end else begin
                        for (int b = 0; b < BW; b++)
                            if (r_be[s][b]) ref_mem[r_add[s]][b*8 +: 8] = r_wdata[s][b*8 +: 8];
                    end
                    exp_q.push_back({8'(s), d});
                    cnt++;
                    last = s;
                end
            end
        end
    end

    // ---------------- response monitor (pops expectations) ----------------
    initial begin
        logic [EW-1:0] e;
        logic [N-1:0]  onehot;
        forever begin
            @(negedge clk);
            if (!rst && s_r_valid_o != '0) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", s_r_valid_o, 0);
                end else begin
                    e      = exp_q.pop_front();
                    onehot = '0;
                    onehot[e[EW-1:DW]] = 1'b1;
                    check("resp_port", s_r_valid_o, onehot);
                    check("resp_data", s_r_rdata_o, e[DW-1:0]);
                    last_rdata[e[EW-1:DW]] = s_r_rdata_o;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic new_req(input int p);
        r_req[p]   = 1'b1;
        r_wen[p]   = (load_only != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        r_add[p]   = AW'($urandom_range(0, 15));
        r_wdata[p] = $urandom;
        r_be[p]    = BW'($urandom_range(1, 15));
    endtask

    task automatic step();
        logic [N-1:0] g;
        @(negedge clk);
        g = s_gnt_o;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (g[p]) r_req[p] = 1'b0;
            if (!r_req[p] && int'($urandom_range(0, 99)) < req_pct) new_req(p);
        end
        m_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    endtask

    task automatic wait_grant(input int p);
        int k;
        k = 0;
        while (r_req[p] && k < 20) begin
            step();
            k++;
        end
        check("grant_timeout", r_req[p], 0);
    endtask

    task automatic drain();
        int   k;
        logic idle;
        req_pct = 0;
        gnt_pct = 100;
        k       = 0;
        idle    = 1'b0;
        while (!idle && k < 80) begin
            step();
            k++;
            idle = (exp_q.size() == 0);
            for (int p = 0; p < N; p++) if (r_req[p]) idle = 1'b0;
        end
        check("drain_idle", idle, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ref_mem[a] = '0;
            bmem[a]    = '0;
        end
        for (int p = 0; p < N; p++) begin
            r_req[p]      = 1'b0;
            r_wen[p]      = 1'b0;
            r_add[p]      = '0;
            r_wdata[p]    = '0;
            r_be[p]       = '0;
            last_rdata[p] = '0;
        end

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Port 0 alone: store 0xA5 to address 3, then load it back.
        r_req[0] = 1'b1; r_wen[0] = 1'b0; r_add[0] = 3; r_wdata[0] = 32'hA5; r_be[0] = '1;
        wait_grant(0);
        r_req[0] = 1'b1; r_wen[0] = 1'b1; r_add[0] = 3; r_wdata[0] = '0;
        wait_grant(0);
        drain();
        check("single_load_data", last_rdata[0], 32'hA5);

        // Both ports holding loads, memory always granting.
        load_only = 1; lat = 1; gnt_pct = 100; req_pct = 100;
        repeat (8) step();
        drain();
        load_only = 0;

        // Slow memory: the ID FIFO fills and throttles requests.
        lat = 4; req_pct = 100; gnt_pct = 100;
        repeat (16) step();
        drain();

        for (int ph = 0; ph < 4; ph++) begin
            lat     = int'($urandom_range(1, 4));
            req_pct = int'($urandom_range(30, 90));
            gnt_pct = int'($urandom_range(50, 100));
            repeat (150) step();
            drain();
        end

        // Response with nothing outstanding.
        stray_cnt++;
        repeat (4) step();
        check("stray_err_sticky", err_o, 1);

        // Reset with transactions in flight.
        lat = 4; req_pct = 100; gnt_pct = 100;
        repeat (3) step();
        rst_kind = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
